// File: rtl/tt_stim_driver.sv
// ----------------------------------------------------------------------------
// tt_stim_driver
//
// Wishbone-programmable stimulus and capture front end for the shared
// TinyTapeout project bank. It builds the 8-bit tt_in bus, drives the project
// select, and samples the selected project's output for firmware readout.
//
// tt_in layout:
//   bit 0     divided project clock (tt_clk)
//   bit 1     project reset (CTRL.tt_rst)
//   bits 7:2  static data (DATA[5:0])
//
// Register map (wbs_adr_i[4:2]):
//   0 CTRL    [0] run, [1] tt_rst, [10:8] sel, [16] irq enable (optional)
//   1 DIV     [DIV_W-1:0] half-period minus one, in system clocks
//   2 DATA    [5:0] -> tt_in[7:2]
//   3 STEP    write N = generate N pulses, read = pulses remaining
//   4 CAPT    [7:0] last sample, [8] changed (read-only, cleared by read)
//   5 CYCLES  [CYC_W-1:0] rising edge count, any write clears
//   6,7       unmapped: read 0, write ignored
//
// Parameters:
//   DIV_W      width of the half-period divider register
//   CYC_W      width of the generated-rising-edge counter
//   RESET_DIV  DIV value after reset
//
// Ports:
//   clock, reset_n           system clock, asynchronous active-low reset
//   wbs_stb_i .. wbs_dat_o   Wishbone slave (single-cycle ack, no back-to-back)
//   tt_in   (out, 8)         stimulus to the project bank
//   tt_sel  (out, 3)         project select to the output mux
//   tt_out  (in, 8)          selected project output from the mux
//   irq     (out, 1)         capture-changed pulse, only with TT_CAPT_IRQ_EN
//
// Build option:
//   TT_CAPT_IRQ_EN  adds the irq port and CTRL[16] irq enable.
// ----------------------------------------------------------------------------
module tt_stim_driver #(
    parameter int DIV_W     = 16,
    parameter int CYC_W     = 32,
    parameter int RESET_DIV = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  tt_in,
    output logic [2:0]  tt_sel,
`ifdef TT_CAPT_IRQ_EN
    output logic        irq,
`endif
    input  logic [7:0]  tt_out
);

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_DIV    = 3'd1;
    localparam logic [2:0] ADR_DATA   = 3'd2;
    localparam logic [2:0] ADR_STEP   = 3'd3;
    localparam logic [2:0] ADR_CAPT   = 3'd4;
    localparam logic [2:0] ADR_CYCLES = 3'd5;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_t;

    // Byte-lane merge for partial writes.
    function automatic logic [31:0] wb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return merged;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    wb_state_t          r_wb_state;
    wb_state_t          w_wb_next;
    logic [31:0]        r_dat_o;

    logic               r_run;
    logic               r_tt_rst;
    logic [2:0]         r_sel;
    logic [DIV_W-1:0]   r_div;
    logic [5:0]         r_data;
    logic [31:0]        r_step;
    logic [7:0]         r_capt;
    logic               r_changed;
    logic [CYC_W-1:0]   r_cycles;

    logic [DIV_W-1:0]   r_divcnt;
    logic               r_tt_clk;

    logic [2:0]         w_adr;
    logic               w_req;
    logic               w_wr;
    logic               w_rd;
    logic               w_wr_ctrl;
    logic               w_wr_div;
    logic               w_wr_data;
    logic               w_wr_step;
    logic               w_wr_cycles;
    logic               w_rd_capt;
    logic [31:0]        w_rdata;

    logic               w_active;
    logic               w_running;
    logic               w_toggle;
    logic               w_rise;
    logic               w_fall;
    logic               w_capt_diff;

    // Only adr[4:2] selects a register; the rest is don't-care.
    logic               w_unused_adr;
    assign w_unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

`ifdef TT_CAPT_IRQ_EN
    logic               r_irq_en;
    logic               r_irq;
`endif

    // ------------------------------------------------------------------------
    // Wishbone handshake: a two-state FSM. A request is only accepted in
    // IDLE, so ack is exactly one cycle wide and always followed by a low
    // cycle. The register access happens on the edge that enters ACK, so the
    // write is visible and read data is valid while ack is high.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would make results depend on statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_wb_state <= WB_IDLE;
        else          r_wb_state <= w_wb_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wb_next = r_wb_state;
        case (r_wb_state)
            WB_IDLE: if (wbs_stb_i && wbs_cyc_i) w_wb_next = WB_ACK;
            WB_ACK:  w_wb_next = WB_IDLE;
            default: w_wb_next = WB_IDLE;
        endcase
    end

    assign w_adr       = wbs_adr_i[4:2];
    assign w_req       = (r_wb_state == WB_IDLE) && wbs_stb_i && wbs_cyc_i;
    assign w_wr        = w_req && wbs_we_i;
    assign w_rd        = w_req && !wbs_we_i;
    assign w_wr_ctrl   = w_wr && (w_adr == ADR_CTRL);
    assign w_wr_div    = w_wr && (w_adr == ADR_DIV);
    assign w_wr_data   = w_wr && (w_adr == ADR_DATA);
    assign w_wr_step   = w_wr && (w_adr == ADR_STEP);
    assign w_wr_cycles = w_wr && (w_adr == ADR_CYCLES);
    assign w_rd_capt   = w_rd && (w_adr == ADR_CAPT);

    // Read mux, sampled into r_dat_o on the request edge.
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            ADR_CTRL: begin
                w_rdata[0]    = r_run;
                w_rdata[1]    = r_tt_rst;
                w_rdata[10:8] = r_sel;
`ifdef TT_CAPT_IRQ_EN
                w_rdata[16]   = r_irq_en;
`endif
            end
            ADR_DIV:    w_rdata[DIV_W-1:0] = r_div;
            ADR_DATA:   w_rdata[5:0]       = r_data;
            ADR_STEP:   w_rdata            = r_step;
            ADR_CAPT:   w_rdata[8:0]       = {r_changed, r_capt};
            ADR_CYCLES: w_rdata[CYC_W-1:0] = r_cycles;
            default:    w_rdata            = '0;
        endcase
    end

    // Read data is only non-zero during the ack cycle of a read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_dat_o <= '0;
        else          r_dat_o <= w_rd ? w_rdata : '0;
    end

    assign wbs_ack_o = (r_wb_state == WB_ACK);
    assign wbs_dat_o = r_dat_o;

    // ------------------------------------------------------------------------
    // Control / configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_tt_rst <= 1'b0;
            r_sel    <= '0;
            r_div    <= DIV_W'(RESET_DIV);
            r_data   <= '0;
`ifdef TT_CAPT_IRQ_EN
            r_irq_en <= 1'b0;
`endif
        end else begin
            if (w_wr_ctrl) begin
                if (wbs_sel_i[0]) {r_tt_rst, r_run} <= wbs_dat_i[1:0];
                if (wbs_sel_i[1]) r_sel <= wbs_dat_i[10:8];
`ifdef TT_CAPT_IRQ_EN
                if (wbs_sel_i[2]) r_irq_en <= wbs_dat_i[16];
`endif
            end
            if (w_wr_div) r_div <= DIV_W'(wb_merge(32'(r_div), wbs_dat_i, wbs_sel_i));
            if (w_wr_data && wbs_sel_i[0]) r_data <= wbs_dat_i[5:0];
        end
    end

    // ------------------------------------------------------------------------
    // Project clock generator
    //
    // The divider keeps running while tt_clk is high even after the clock
    // becomes inactive, so the high phase always completes at full length and
    // the generator can only come to rest with tt_clk low. While at rest the
    // divider is held at zero so a restart begins with a full low phase.
    // A DIV write restarts the current phase and suppresses that cycle's
    // toggle.
    // ------------------------------------------------------------------------
    assign w_active  = r_run || (r_step != '0);
    assign w_running = w_active || r_tt_clk;
    assign w_toggle  = w_running && (r_divcnt == r_div) && !w_wr_div;
    assign w_rise    = w_toggle && !r_tt_clk;
    assign w_fall    = w_toggle && r_tt_clk;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_divcnt <= '0;
            r_tt_clk <= 1'b0;
        end else begin
            if (w_wr_div || !w_running || w_toggle) r_divcnt <= '0;
            else                                   r_divcnt <= r_divcnt + DIV_W'(1);
            if (w_toggle) r_tt_clk <= !r_tt_clk;
        end
    end

    // STEP: a write overwrites the remaining count; each rising edge consumes
    // one pulse. A write on the same cycle as a rising edge takes the written
    // value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                       r_step <= '0;
        else if (w_wr_step)                 r_step <= wb_merge(r_step, wbs_dat_i, wbs_sel_i);
        else if (w_rise && r_step != '0)    r_step <= r_step - 32'd1;
    end

    // CYCLES: clear from the bus wins over a coincident rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         r_cycles <= '0;
        else if (w_wr_cycles) r_cycles <= '0;
        else if (w_rise)      r_cycles <= r_cycles + CYC_W'(1);
    end

    // ------------------------------------------------------------------------
    // Capture on the falling edge of tt_clk. The projects are clocked from
    // tt_clk, which is generated in this clock domain, so tt_out has settled
    // a full high phase before it is sampled here.
    // ------------------------------------------------------------------------
    assign w_capt_diff = (tt_out != r_capt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_capt    <= '0;
            r_changed <= 1'b0;
        end else begin
            if (w_fall) r_capt <= tt_out;
            // A new change on the same cycle as the clearing read wins.
            if (w_fall && w_capt_diff) r_changed <= 1'b1;
            else if (w_rd_capt)        r_changed <= 1'b0;
        end
    end

`ifdef TT_CAPT_IRQ_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= w_fall && w_capt_diff && r_irq_en;
    end

    assign irq = r_irq;
`endif

    // ------------------------------------------------------------------------
    // Outputs: all straight from flops, no combinational path from the bus.
    // ------------------------------------------------------------------------
    assign tt_in  = {r_data, r_tt_rst, r_tt_clk};
    assign tt_sel = r_sel;

endmodule

// File: tb/tb_tt_stim_driver.sv
// ----------------------------------------------------------------------------
// tb_tt_stim_driver
//
// Directed bench for tt_stim_driver. Register reads go through a scoreboard
// queue: the expected value is queued when the read is issued and compared
// when the ack returns. Edge monitors on tt_in[0] record rising/falling edge
// counts and the system-clock cycle on which each happened.
// ----------------------------------------------------------------------------
module tb_tt_stim_driver;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DIV    = 3'd1;
    localparam logic [2:0] A_DATA   = 3'd2;
    localparam logic [2:0] A_STEP   = 3'd3;
    localparam logic [2:0] A_CAPT   = 3'd4;
    localparam logic [2:0] A_CYCLES = 3'd5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  tt_in;
    logic [2:0]  tt_sel;
    logic [7:0]  tt_out;
`ifdef TT_CAPT_IRQ_EN
    logic        irq;
`endif

    tt_stim_driver #(
        .DIV_W     (16),
        .CYC_W     (32),
        .RESET_DIV (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .tt_in     (tt_in),
        .tt_sel    (tt_sel),
`ifdef TT_CAPT_IRQ_EN
        .irq       (irq),
`endif
        .tt_out    (tt_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Edge monitors on the generated project clock.
    int cyc       = 0;
    int rise_cnt  = 0;
    int fall_cnt  = 0;
    int last_rise = 0;
    int last_fall = 0;

    always @(posedge clock) cyc++;
    always @(posedge tt_in[0]) begin rise_cnt++; last_rise = cyc; end
    always @(negedge tt_in[0]) begin fall_cnt++; last_fall = cyc; end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One Wishbone transaction, bounded wait for ack, then verifies ack drops.
    task automatic wb_cycle(input logic we, input logic [2:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        @(posedge clock); #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {27'd0, a, 2'b00};
        wbs_dat_i = d;
        wbs_sel_i = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (wbs_ack_o) begin ok = 1'b1; break; end
        end
        rd = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        check("wb_ack_seen", {31'd0, ok}, 32'd1);
        @(posedge clock); #1;
        check("wb_ack_drop", {31'd0, wbs_ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] rd;
        wb_cycle(1'b1, a, d, s, rd);
    endtask

    task automatic wb_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        sb_item_t    item;
        sb_q.push_back('{tag: tag, exp: exp});
        wb_cycle(1'b0, a, 32'd0, 4'hF, rd);
        item = sb_q.pop_front();
        check(item.tag, rd, item.exp);
    endtask

    // Waits until an edge counter reaches target, bounded by budget cycles.
    task automatic wait_edges(input bit rising, input int target, input int budget, input string tag);
        int cnt;
        cnt = rising ? rise_cnt : fall_cnt;
        for (int i = 0; i < budget && cnt < target; i++) begin
            tick(1);
            cnt = rising ? rise_cnt : fall_cnt;
        end
        check(tag, {31'd0, cnt >= target}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_r, base_f, t_r1, t_f1, t_r2;
        logic any_ack;

        reset_n   = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        tt_out    = 8'h00;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        // ---- Reset state, idle bus ----
        any_ack = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            any_ack |= wbs_ack_o;
        end
        check("idle_no_ack", {31'd0, any_ack}, 32'd0);
        check("rst_tt_in", {24'd0, tt_in}, 32'h00);
        check("rst_tt_sel", {29'd0, tt_sel}, 32'd0);
        check("rst_dat_o", wbs_dat_o, 32'd0);
        wb_read(A_CTRL,   32'd0, "rst_ctrl");
        wb_read(A_DIV,    32'd4, "rst_div");
        wb_read(A_DATA,   32'd0, "rst_data");
        wb_read(A_STEP,   32'd0, "rst_step");
        wb_read(A_CAPT,   32'd0, "rst_capt");
        wb_read(A_CYCLES, 32'd0, "rst_cycles");
        wb_read(3'd6,     32'd0, "unmapped6");
        wb_write(3'd7, 32'hFFFF_FFFF);
        wb_read(3'd7,     32'd0, "unmapped7");

        // ---- Free run: DIV=2 -> period 6, high 3; stop after 10 rises ----
        wb_write(A_DIV, 32'd2);
        wb_write(A_CYCLES, 32'd0);
        base_r = rise_cnt;
        base_f = fall_cnt;
        wb_write(A_CTRL, 32'h1);
        wait_edges(1'b1, base_r + 1, 40, "run_rise1");
        t_r1 = last_rise;
        wait_edges(1'b0, base_f + 1, 40, "run_fall1");
        t_f1 = last_fall;
        wait_edges(1'b1, base_r + 2, 40, "run_rise2");
        t_r2 = last_rise;
        check("run_high_len", t_f1 - t_r1, 32'd3);
        check("run_period", t_r2 - t_r1, 32'd6);
        wait_edges(1'b1, base_r + 10, 100, "run_rise10");
        wb_write(A_CTRL, 32'h0);
        tick(20);
        check("run_rises", rise_cnt - base_r, 32'd10);
        check("run_halt_low", {31'd0, tt_in[0]}, 32'd0);
        wb_read(A_CYCLES, 32'd10, "run_cycles");

        // ---- STEP=3 with run=0 ----
        wb_write(A_CYCLES, 32'd0);
        base_r = rise_cnt;
        base_f = fall_cnt;
        wb_write(A_STEP, 32'd3);
        wait_edges(1'b0, base_f + 3, 80, "step_falls");
        tick(20);
        check("step_rises", rise_cnt - base_r, 32'd3);
        check("step_fall_cnt", fall_cnt - base_f, 32'd3);
        check("step_halt_low", {31'd0, tt_in[0]}, 32'd0);
        wb_read(A_STEP,   32'd0, "step_remaining");
        wb_read(A_CYCLES, 32'd3, "step_cycles");

        // ---- Drop run mid-high with DIV=7: high must last 8 clocks ----
        wb_write(A_DIV, 32'd7);
        base_r = rise_cnt;
        base_f = fall_cnt;
        wb_write(A_CTRL, 32'h1);
        wait_edges(1'b1, base_r + 1, 40, "norunt_rise");
        wb_write(A_CTRL, 32'h0);
        wait_edges(1'b0, base_f + 1, 40, "norunt_fall");
        check("norunt_high_len", last_fall - last_rise, 32'd8);
        tick(40);
        check("norunt_rises", rise_cnt - base_r, 32'd1);
        check("norunt_low", {31'd0, tt_in[0]}, 32'd0);

        // ---- DIV=0 boundary: toggles every clock ----
        wb_write(A_DIV, 32'd0);
        base_r = rise_cnt;
        base_f = fall_cnt;
        wb_write(A_STEP, 32'd2);
        wait_edges(1'b0, base_f + 2, 20, "div0_falls");
        tick(10);
        check("div0_high_len", last_fall - last_rise, 32'd1);
        check("div0_rises", rise_cnt - base_r, 32'd2);

        // ---- Capture: 0xA5 then 0x5A; changed flag clears on read ----
        wb_write(A_DIV, 32'd1);
        tt_out = 8'hA5;
        base_f = fall_cnt;
        wb_write(A_STEP, 32'd1);
        wait_edges(1'b0, base_f + 1, 30, "capt_fall1");
        tt_out = 8'h5A;
        wb_write(A_STEP, 32'd1);
        wait_edges(1'b0, base_f + 2, 30, "capt_fall2");
        tick(5);
        wb_read(A_CAPT, 32'h15A, "capt_changed");
        wb_read(A_CAPT, 32'h05A, "capt_cleared");

        // ---- CYCLES: any write clears ----
        wb_write(A_CYCLES, 32'hDEAD_BEEF);
        wb_read(A_CYCLES, 32'd0, "cycles_clear");

        // ---- Byte-lane write on DIV ----
        wb_write(A_DIV, 32'h0000_1234);
        wb_write(A_DIV, 32'h0000_ABCD, 4'b0001);
        wb_read(A_DIV, 32'h0000_12CD, "div_bytelane");

        // ---- DATA / tt_rst / sel to tt_in / tt_sel ----
        wb_write(A_DIV, 32'd3);
        wb_write(A_DATA, 32'h2A);
        wb_write(A_CTRL, 32'h502);
        check("data_tt_in", {24'd0, tt_in}, 32'hAA);
        check("data_tt_sel", {29'd0, tt_sel}, 32'd5);
        wb_write(A_CTRL, 32'h503);
        wb_write(A_CTRL, 32'h0000_0100, 4'b0010);
        wb_read(A_CTRL, 32'h103, "ctrl_byte1");
        check("ctrl_byte1_sel", {29'd0, tt_sel}, 32'd1);
        check("ctrl_tt_in_hi", {24'd0, tt_in & 8'hFE}, 32'hAA);
        wb_write(A_CTRL, 32'h0001_0103);
`ifdef TT_CAPT_IRQ_EN
        wb_read(A_CTRL, 32'h0001_0103, "ctrl_irq_en");
`else
        wb_read(A_CTRL, 32'h0000_0103, "ctrl_irq_en");
`endif
        wb_write(A_CTRL, 32'h0);
        tick(20);
        check("ctrl_stop_low", {31'd0, tt_in[0]}, 32'd0);

        // ---- Asynchronous reset during a high phase ----
        wb_write(A_DIV, 32'd7);
        base_r = rise_cnt;
        wb_write(A_CTRL, 32'h1);
        wait_edges(1'b1, base_r + 1, 40, "arst_rise");
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("arst_tt_in", {24'd0, tt_in}, 32'h00);
        check("arst_ack", {31'd0, wbs_ack_o}, 32'd0);
        #10 reset_n = 1'b1;
        base_r = rise_cnt;
        tick(30);
        check("arst_no_edges", rise_cnt - base_r, 32'd0);
        wb_read(A_DIV,  32'd4, "arst_div");
        wb_read(A_CTRL, 32'd0, "arst_ctrl");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
